l2_cache: RTL and testbench
===========================

# l2_cache

Unified, direct-mapped, write-back L2 cache between the L1 data cache's memory port and main memory. Upstream it accepts whole 128-bit line reads and line write-backs using the L1's level-held request / one-cycle-ready protocol. Downstream it issues the same protocol to main memory. Misses allocate on both read and write, and dirty victims are written back before a line is replaced.

## Interface
- NUM_OF_SET, 64, number of sets (lines); power of two.
- SET_OFFSET, 6, log2(NUM_OF_SET); tag width = 28-SET_OFFSET.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- proc_read  in  1  line read request from L1; held until proc_ready.
- proc_write  in  1  line write-back from L1; held until proc_ready.
- proc_addr  in  28  line address; [SET_OFFSET-1:0] = set index, [27:SET_OFFSET] = tag.
- proc_wdata  in  128  write-back line data.
- proc_rdata  out  128  read line; valid only while proc_ready=1, else 0.
- proc_ready  out  1  one-cycle completion pulse.
- mem_read  out  1  line read to main memory.
- mem_write  out  1  line write to main memory.
- mem_addr  out  28  main-memory line address; 0 when no request.
- mem_wdata  out  128  main-memory write data; 0 when no write.
- mem_rdata  in  128  main-memory read data; valid in the mem_ready cycle.
- mem_ready  in  1  main-memory completion pulse.

## Operation
- Storage per set: data[127:0], tag, valid, dirty.
- Request decode:
  - read = proc_read & ~proc_write.
  - write = proc_write & ~proc_read.
  - Both high or both low means no request.
- States: IDLE, LOOKUP, WB, FETCH, RESP.
- IDLE:
  - On a valid request, latch op, proc_addr and proc_wdata into request registers.
  - Go to LOOKUP.
  - No outputs asserted.
- LOOKUP: compare stored tag with the latched tag; hit = valid & match.
  - Read hit: resp_data = line → RESP.
  - Write hit: overwrite line, dirty=1 → RESP.
  - Write miss with clean or invalid victim: install line (tag, valid=1, dirty=1) → RESP.
  - Any miss with a valid, dirty victim → WB.
  - Read miss with a clean or invalid victim → FETCH.
- WB:
  - Drive mem_write=1, mem_addr={victim tag, set}, mem_wdata=victim data.
  - Hold these until mem_ready is sampled high.
  - On that edge, clear dirty, then:
    - read op → FETCH;
    - write op → install proc line with dirty=1 → RESP.
- FETCH:
  - Drive mem_read=1, mem_addr={req tag, set} until mem_ready is sampled high.
  - On that edge, store mem_rdata with tag, valid=1, dirty=0.
  - Set resp_data = mem_rdata → RESP.
- RESP:
  - proc_ready=1 for exactly one cycle.
  - proc_rdata = resp_data for reads, 0 for writes.
  - → IDLE.
- Request inputs are ignored outside IDLE; L1 is required to hold them stable.
- Reset (async, any state):
  - state=IDLE; all valid and dirty bits=0.
  - All outputs 0 immediately.
  - Any in-flight memory request is abandoned.
  - Data and tag arrays need not be cleared.

## Timing
- Request first seen in cycle 0. Hit (read or write), or write miss with a clean victim: proc_ready in cycle 2.
- Read miss, clean victim:
  - mem_read from cycle 2.
  - mem_ready seen in cycle k → proc_ready in cycle k+1.
- Dirty miss:
  - mem_write from cycle 2 until mem_ready seen in cycle k.
  - Read op: mem_read from k+1, then as for a clean read miss.
  - Write op: proc_ready in cycle k+1.
- Memory request outputs stay high during the mem_ready cycle and drop the following cycle.
- Main memory must tolerate this and must not restart on it.
- L1 samples proc_ready through a register, so its request is still high in the proc_ready cycle. The block is in RESP then and ignores it.
- A new request arriving in the cycle after RESP (L1 write-back followed immediately by its refill read) is accepted in IDLE without bubbles.
- mem_addr and mem_wdata are combinational from state and registers.
- proc_rdata and proc_ready are registered.

## Test plan
- Cold read: reset, read 0x0000040; memory ready 3 cycles after request → exactly one mem_read to 0x0000040, then proc_ready one cycle later with the memory line.
- Read hit: repeat the same read → proc_ready in cycle 2, no mem_read/mem_write, same data returned.
- Write hit then eviction:
  - Write line 0x0000040 with 128'hA5…; read 0x0001040 (same set 0).
  - Required: mem_write to 0x0000040 with 128'hA5…, then mem_read to 0x0001040, then proc_ready.
- Write miss, clean victim: write 0x0000081 into an invalid set → proc_ready in cycle 2, no memory traffic; a later read of 0x0000081 returns the written data.
- Back-to-back: L1 write-back of 0x0000002 followed next cycle by read 0x0000042 → both complete, each with exactly one proc_ready pulse.
- Reset mid-FETCH: assert rst_n=0 while mem_read=1 → mem_read and proc_ready drop to 0 immediately; after release, a read of the previously resident address misses.

Source files
------------

// File: rtl/l2_cache.sv
// l2_cache: unified, direct-mapped, write-back L2 cache with write-allocate.
// Upstream and downstream both use the level-held request / one-cycle-ready handshake.
module l2_cache #(
   parameter int unsigned NUM_OF_SET = 64,
   parameter int unsigned SET_OFFSET = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         proc_read,
   input  logic         proc_write,
   input  logic [27:0]  proc_addr,
   input  logic [127:0] proc_wdata,
   output logic [127:0] proc_rdata,
   output logic         proc_ready,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
);

   localparam int unsigned ADDR_W = 28;
   localparam int unsigned LINE_W = 128;
   localparam int unsigned TAG_W  = ADDR_W - SET_OFFSET;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_WB,
      S_FETCH,
      S_RESP
   } state_e;

   state_e              state_q;
   logic                op_wr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LINE_W-1:0]   wdata_q;
   logic [LINE_W-1:0]   rdata_q;
   logic                ready_q;

   logic [LINE_W-1:0]   data_q [NUM_OF_SET];
   logic [TAG_W-1:0]    tag_q  [NUM_OF_SET];
   logic [NUM_OF_SET-1:0] valid_q;
   logic [NUM_OF_SET-1:0] dirty_q;

   logic [SET_OFFSET-1:0] set_c;
   logic [TAG_W-1:0]      tag_c;
   logic                  req_rd_c;
   logic                  req_wr_c;
   logic                  hit_c;
   logic                  victim_dirty_c;
   logic                  line_we_c;
   logic                  line_dirty_c;
   logic                  dirty_clr_c;
   logic [LINE_W-1:0]     line_wdata_c;

   assign req_rd_c       = proc_read & ~proc_write;
   assign req_wr_c       = proc_write & ~proc_read;
   assign set_c          = addr_q[SET_OFFSET-1:0];
   assign tag_c          = addr_q[ADDR_W-1:SET_OFFSET];
   assign hit_c          = valid_q[set_c] & (tag_q[set_c] == tag_c);
   assign victim_dirty_c = valid_q[set_c] & dirty_q[set_c];

   assign proc_rdata = rdata_q;
   assign proc_ready = ready_q;

   // Line install / dirty-clear decisions for the set addressed by the latched request
   always_comb begin
      line_we_c    = 1'b0;
      line_dirty_c = 1'b0;
      dirty_clr_c  = 1'b0;
      line_wdata_c = wdata_q;
      case (state_q)
         S_LOOKUP: begin
            if (op_wr_q && (hit_c || !victim_dirty_c)) begin
               line_we_c    = 1'b1;
               line_dirty_c = 1'b1;
            end
         end
         S_WB: begin
            if (mem_ready) begin
               if (op_wr_q) begin
                  line_we_c    = 1'b1;
                  line_dirty_c = 1'b1;
               end else begin
                  dirty_clr_c = 1'b1;
               end
            end
         end
         S_FETCH: begin
            if (mem_ready) begin
               line_we_c    = 1'b1;
               line_wdata_c = mem_rdata;
            end
         end
         default: ;
      endcase
   end

   // Memory-side request, decoded from the state register and the stored victim
   always_comb begin
      mem_read  = (state_q == S_FETCH);
      mem_write = (state_q == S_WB);
      mem_addr  = '0;
      mem_wdata = '0;
      if (state_q == S_WB) begin
         mem_addr  = {tag_q[set_c], set_c};
         mem_wdata = data_q[set_c];
      end else if (state_q == S_FETCH) begin
         mem_addr = addr_q;
      end
   end

   // Valid/dirty bits: cleared by reset, updated on install or write-back completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we_c) begin
         valid_q[set_c] <= 1'b1;
         dirty_q[set_c] <= line_dirty_c;
      end else if (dirty_clr_c) begin
         dirty_q[set_c] <= 1'b0;
      end
   end

   // Data and tag arrays carry no reset; valid bits qualify them
   always_ff @(posedge clk) begin
      if (line_we_c) begin
         data_q[set_c] <= line_wdata_c;
         tag_q[set_c]  <= tag_c;
      end
   end

   // Control FSM with registered response outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         rdata_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (req_rd_c || req_wr_c) begin
                  op_wr_q <= req_wr_c;
                  addr_q  <= proc_addr;
                  wdata_q <= proc_wdata;
                  state_q <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit_c) begin
                  ready_q <= 1'b1;
                  rdata_q <= op_wr_q ? '0 : data_q[set_c];
                  state_q <= S_RESP;
               end else if (victim_dirty_c) begin
                  state_q <= S_WB;
               end else if (op_wr_q) begin
                  ready_q <= 1'b1;
                  state_q <= S_RESP;
               end else begin
                  state_q <= S_FETCH;
               end
            end
            S_WB: begin
               if (mem_ready) begin
                  if (op_wr_q) begin
                     ready_q <= 1'b1;
                     state_q <= S_RESP;
                  end else begin
                     state_q <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (mem_ready) begin
                  ready_q <= 1'b1;
                  rdata_q <= mem_rdata;
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_cache.sv
// tb_l2_cache: self-checking bench for l2_cache with a main-memory responder and a behavioural cache model.
`timescale 1ns/1ps
module tb_l2_cache;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         proc_read, proc_write;
   logic [27:0]  proc_addr;
   logic [127:0] proc_wdata, proc_rdata;
   logic         proc_ready;
   logic         mem_read, mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   int tests_run    = 0;
   int tests_failed = 0;

   l2_cache #(.NUM_OF_SET(64), .SET_OFFSET(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_ready (proc_ready),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   always #5 clk = ~clk;

   // Power-on contents of main memory: a pattern unique to each line address
   function automatic logic [127:0] init_line(input logic [27:0] a);
      return {4{4'hA ^ a[3:0], a}} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
   endfunction

   // ---------------- main-memory responder ----------------
   int           mem_lat = 1;
   int           rsp_cnt = 0;
   int           obs_cnt = 0;
   logic [157:0] obs_e [2];
   logic [127:0] mm [logic [27:0]];

   function automatic logic [127:0] mm_rd(input logic [27:0] a);
      if (mm.exists(a)) return mm[a];
      return init_line(a);
   endfunction

   // Raises mem_ready in the mem_lat-th cycle a request is held; logs each completed access
   always @(negedge clk) begin
      if (!rst_n) begin
         mem_ready = 1'b0;
         mem_rdata = '0;
         rsp_cnt   = 0;
      end else begin
         if (mem_ready) begin
            mem_ready = 1'b0;
            mem_rdata = '0;
            rsp_cnt   = 0;
         end
         if (mem_read || mem_write) begin
            rsp_cnt++;
            if (rsp_cnt >= mem_lat) begin
               mem_ready = 1'b1;
               if (mem_write) mm[mem_addr] = mem_wdata;
               else           mem_rdata = mm_rd(mem_addr);
               if (obs_cnt < 2) obs_e[obs_cnt] = {1'b1, mem_write, mem_addr, mem_wdata};
               obs_cnt++;
            end
         end
      end
   end

   // ---------------- behavioural cache model ----------------
   bit           m_valid [64];
   bit           m_dirty [64];
   logic [21:0]  m_tag   [64];
   logic [127:0] m_data  [64];
   logic [127:0] em [logic [27:0]];

   int           exp_cyc;
   logic [127:0] exp_rdata;
   logic [323:0] exp_tr;

   function automatic logic [127:0] em_rd(input logic [27:0] a);
      if (em.exists(a)) return em[a];
      return init_line(a);
   endfunction

   task automatic model_reset();
      foreach (m_valid[i]) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
   endtask

   // Expected response latency, read data and memory traffic for one request
   task automatic model_txn(input bit wr, input logic [27:0] a, input logic [127:0] wd);
      int           s;
      int           n;
      logic [21:0]  t;
      bit           hit;
      logic [157:0] e [2];
      s = int'(a[5:0]);
      t = a[27:6];
      hit = m_valid[s] && (m_tag[s] == t);
      n = 0;
      e[0] = '0;
      e[1] = '0;
      exp_cyc = 2;
      exp_rdata = '0;
      if (!hit && m_valid[s] && m_dirty[s]) begin
         e[n] = {1'b1, 1'b1, m_tag[s], 6'(s), m_data[s]};
         n++;
         em[{m_tag[s], 6'(s)}] = m_data[s];
         exp_cyc += mem_lat;
      end
      if (!hit) begin
         if (!wr) begin
            e[n] = {1'b1, 1'b0, a, 128'h0};
            n++;
            exp_cyc += mem_lat;
            m_data[s] = em_rd(a);
         end
         m_valid[s] = 1'b1;
         m_tag[s]   = t;
         m_dirty[s] = 1'b0;
      end
      if (wr) begin
         m_data[s]  = wd;
         m_dirty[s] = 1'b1;
      end else begin
         exp_rdata = m_data[s];
      end
      exp_tr = {8'(n), e[1], e[0]};
   endtask

   // ---------------- L1-side driver ----------------
   int           obs_cyc;
   logic [127:0] obs_rdata;
   logic [128:0] obs_pre;
   logic [323:0] obs_tr;

   // Holds the request like the L1 does (until one cycle past proc_ready) and records what came back
   task automatic run_txn(input bit wr, input logic [27:0] a, input logic [127:0] wd);
      obs_cnt   = 0;
      obs_e[0]  = '0;
      obs_e[1]  = '0;
      obs_cyc   = -1;
      obs_rdata = '0;
      obs_pre   = '0;
      proc_read  = !wr;
      proc_write = wr;
      proc_addr  = a;
      proc_wdata = wd;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (n == 0) obs_pre = {proc_ready, proc_rdata};
         if (proc_ready) begin
            obs_cyc   = n;
            obs_rdata = proc_rdata;
            break;
         end
      end
      @(posedge clk);
      #1;
      obs_tr = {8'(obs_cnt), obs_e[1], obs_e[0]};
   endtask

   task automatic idle_bus(input int cycles);
      proc_read  = 1'b0;
      proc_write = 1'b0;
      proc_addr  = '0;
      proc_wdata = '0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({proc_ready, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: ready=%b rd=%b wr=%b addr=%h, want all zero",
                  proc_ready, mem_read, mem_write, mem_addr);
      end
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_no_request();
      int seen;
      seen = 0;
      obs_cnt = 0;
      proc_read = 1'b1; proc_write = 1'b1; proc_addr = 28'h0000040;
      repeat (5) begin
         @(negedge clk);
         if (proc_ready || mem_read || mem_write) seen++;
      end
      idle_bus(1);
      tests_run++;
      if (seen !== 0 || obs_cnt !== 0) begin
         tests_failed++;
         $display("FAIL both_high_ignored: active cycles=%0d mem accesses=%0d, want 0 and 0", seen, obs_cnt);
      end
   endtask

   task automatic test_cold_read();
      mem_lat = 3;
      model_txn(1'b0, 28'h0000040, '0);
      run_txn(1'b0, 28'h0000040, '0);
      idle_bus(2);
      tests_run++;
      if (obs_cyc !== exp_cyc || obs_rdata !== exp_rdata) begin
         tests_failed++;
         $display("FAIL cold_read resp: cyc=%0d data=%h, want cyc=%0d data=%h", obs_cyc, obs_rdata, exp_cyc, exp_rdata);
      end
      tests_run++;
      if (obs_cnt !== 1 || obs_e[0][156] !== 1'b0 || obs_e[0][155:128] !== 28'h0000040) begin
         tests_failed++;
         $display("FAIL cold_read traffic: count=%0d entry=%h, want one read of 0000040", obs_cnt, obs_e[0]);
      end
      tests_run++;
      if (obs_pre !== '0) begin
         tests_failed++;
         $display("FAIL cold_read idle_outputs: got %h want 0", obs_pre);
      end
   endtask

   task automatic test_read_hit();
      mem_lat = 2;
      model_txn(1'b0, 28'h0000040, '0);
      run_txn(1'b0, 28'h0000040, '0);
      idle_bus(1);
      tests_run++;
      if (obs_cyc !== 2 || obs_rdata !== init_line(28'h0000040)) begin
         tests_failed++;
         $display("FAIL read_hit resp: cyc=%0d data=%h, want cyc=2 data=%h", obs_cyc, obs_rdata, init_line(28'h0000040));
      end
      tests_run++;
      if (obs_tr !== exp_tr) begin
         tests_failed++;
         $display("FAIL read_hit traffic: got %h want %h", obs_tr, exp_tr);
      end
   endtask

   task automatic test_write_evict();
      logic [127:0] a5;
      a5 = {16{8'hA5}};
      mem_lat = 2;
      model_txn(1'b1, 28'h0000040, a5);
      run_txn(1'b1, 28'h0000040, a5);
      tests_run++;
      if (obs_cyc !== exp_cyc || obs_tr !== exp_tr || obs_rdata !== '0) begin
         tests_failed++;
         $display("FAIL write_hit: cyc=%0d cnt=%0d data=%h, want cyc=%0d cnt=0 data=0", obs_cyc, obs_cnt, obs_rdata, exp_cyc);
      end
      idle_bus(1);
      model_txn(1'b0, 28'h0001040, '0);
      run_txn(1'b0, 28'h0001040, '0);
      idle_bus(1);
      tests_run++;
      if (obs_cnt !== 2 || obs_e[0] !== {2'b11, 28'h0000040, a5} || obs_e[1] !== {2'b10, 28'h0001040, 128'h0}) begin
         tests_failed++;
         $display("FAIL evict traffic: got %h want %h", obs_tr, exp_tr);
      end
      tests_run++;
      if (obs_cyc !== exp_cyc || obs_rdata !== exp_rdata) begin
         tests_failed++;
         $display("FAIL evict resp: cyc=%0d data=%h, want cyc=%0d data=%h", obs_cyc, obs_rdata, exp_cyc, exp_rdata);
      end
   endtask

   task automatic test_write_miss_clean();
      logic [127:0] wd;
      wd = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      mem_lat = 3;
      model_txn(1'b1, 28'h0000081, wd);
      run_txn(1'b1, 28'h0000081, wd);
      idle_bus(1);
      tests_run++;
      if (obs_cyc !== 2 || obs_cnt !== 0) begin
         tests_failed++;
         $display("FAIL write_miss_clean: cyc=%0d mem accesses=%0d, want cyc=2 accesses=0", obs_cyc, obs_cnt);
      end
      model_txn(1'b0, 28'h0000081, '0);
      run_txn(1'b0, 28'h0000081, '0);
      idle_bus(1);
      tests_run++;
      if (obs_cyc !== 2 || obs_rdata !== wd || obs_tr !== exp_tr) begin
         tests_failed++;
         $display("FAIL write_miss_readback: cyc=%0d data=%h, want cyc=2 data=%h", obs_cyc, obs_rdata, wd);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] wd;
      wd = 128'hDEAD_BEEF_0000_0002_CAFE_F00D_1234_5678;
      mem_lat = 2;
      model_txn(1'b1, 28'h0000002, wd);
      run_txn(1'b1, 28'h0000002, wd);
      tests_run++;
      if (obs_cyc !== exp_cyc || obs_tr !== exp_tr) begin
         tests_failed++;
         $display("FAIL b2b_write: cyc=%0d traffic=%h, want cyc=%0d traffic=%h", obs_cyc, obs_tr, exp_cyc, exp_tr);
      end
      model_txn(1'b0, 28'h0000042, '0);
      run_txn(1'b0, 28'h0000042, '0);
      idle_bus(1);
      tests_run++;
      if (obs_pre !== '0 || obs_cyc !== exp_cyc || obs_rdata !== exp_rdata) begin
         tests_failed++;
         $display("FAIL b2b_read resp: pre=%h cyc=%0d data=%h, want pre=0 cyc=%0d data=%h",
                  obs_pre, obs_cyc, obs_rdata, exp_cyc, exp_rdata);
      end
      tests_run++;
      if (obs_tr !== exp_tr) begin
         tests_failed++;
         $display("FAIL b2b_read traffic: got %h want %h", obs_tr, exp_tr);
      end
      tests_run++;
      if (proc_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_pulse_width: proc_ready=%b after response, want 0", proc_ready);
      end
   endtask

   task automatic test_reset_mid_fetch();
      bit got;
      mem_lat = 2;
      model_txn(1'b0, 28'h0000003, '0);
      run_txn(1'b0, 28'h0000003, '0);
      idle_bus(1);
      mem_lat = 20;
      got = 1'b0;
      proc_read = 1'b1; proc_write = 1'b0; proc_addr = 28'h0000007;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (mem_read) begin
            got = 1'b1;
            break;
         end
      end
      tests_run++;
      if (!got) begin
         tests_failed++;
         $display("FAIL fetch_start: mem_read=%b, want 1 within 10 cycles", mem_read);
      end
      rst_n = 1'b0;
      proc_read = 1'b0;
      #1;
      tests_run++;
      if ({mem_read, mem_write, proc_ready, mem_addr, proc_rdata} !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid_fetch: mem_read=%b ready=%b addr=%h, want 0 0 0", mem_read, proc_ready, mem_addr);
      end
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mem_lat = 2;
      model_txn(1'b0, 28'h0000003, '0);
      run_txn(1'b0, 28'h0000003, '0);
      idle_bus(1);
      tests_run++;
      if (obs_cnt !== 1 || obs_tr !== exp_tr || obs_rdata !== exp_rdata) begin
         tests_failed++;
         $display("FAIL post_reset_miss: accesses=%0d data=%h, want accesses=1 data=%h", obs_cnt, obs_rdata, exp_rdata);
      end
   endtask

   task automatic test_random();
      bit           wr;
      logic [27:0]  a;
      logic [127:0] wd;
      for (int i = 0; i < 60; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
         wd = {$urandom, $urandom, $urandom, $urandom};
         mem_lat = int'($urandom_range(1, 4));
         model_txn(wr, a, wd);
         run_txn(wr, a, wd);
         tests_run++;
         if (obs_cyc !== exp_cyc || obs_rdata !== exp_rdata || obs_pre !== '0) begin
            tests_failed++;
            $display("FAIL random[%0d] resp %s %h: cyc=%0d data=%h, want cyc=%0d data=%h",
                     i, wr ? "wr" : "rd", a, obs_cyc, obs_rdata, exp_cyc, exp_rdata);
         end
         tests_run++;
         if (obs_tr !== exp_tr) begin
            tests_failed++;
            $display("FAIL random[%0d] traffic %h: got %h want %h", i, a, obs_tr, exp_tr);
         end
         idle_bus(int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      test_reset();
      test_no_request();
      test_cold_read();
      test_read_hit();
      test_write_evict();
      test_write_miss_clean();
      test_back_to_back();
      test_reset_mid_fetch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
      $fatal(1);
   end

endmodule
